// File: rtl/pipeline_control_unit.sv
// Pipeline control: per-stage enables, bubble/flush strobes, registered EX forwarding selects,
// MULT/DIV wait and halt states. Define PIPE_CTRL_PERF_EN to add stall/flush performance counters.

module pipeline_control_unit #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      haz,
  input  logic             haz_stall,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             halt,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_br,
`ifdef PIPE_CTRL_PERF_EN
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`else
  output logic             busy
`endif
);

  localparam int unsigned WaitW    = (MULDIV_CYCLES > 0) ? $clog2(MULDIV_CYCLES + 1) : 1;
  localparam int unsigned WaitLoad = (MULDIV_CYCLES > 0) ? MULDIV_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    StRun        = 2'd0,
    StMuldivWait = 2'd1,
    StHalted     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             halt_pend_q, halt_pend_d;

  logic pc_we_c, if_id_we_c, id_ex_we_c, bubble_c, flush_c, busy_c;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_br_sel;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    halt_pend_d = halt_pend_q;
    pc_we_c     = 1'b0;
    if_id_we_c  = 1'b0;
    id_ex_we_c  = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    busy_c      = 1'b0;

    case (state_q)
      StRun: begin
        if (halt) begin
          // Halt itself moves into EX; everything younger is squashed.
          id_ex_we_c = 1'b1;
          flush_c    = 1'b1;
          state_d    = StHalted;
        end else if (branch_taken) begin
          pc_we_c    = 1'b1;
          if_id_we_c = 1'b1;
          id_ex_we_c = 1'b1;
          bubble_c   = 1'b1;
          flush_c    = 1'b1;
        end else if (muldiv_start) begin
          pc_we_c    = 1'b1;
          if_id_we_c = 1'b1;
          id_ex_we_c = 1'b1;
          if (MULDIV_CYCLES > 0) begin
            wait_cnt_d = WaitW'(WaitLoad);
            state_d    = StMuldivWait;
          end
        end else if (haz_stall) begin
          id_ex_we_c = 1'b1;
          bubble_c   = 1'b1;
        end else begin
          pc_we_c    = 1'b1;
          if_id_we_c = 1'b1;
          id_ex_we_c = 1'b1;
        end
      end

      StMuldivWait: begin
        busy_c      = 1'b1;
        halt_pend_d = halt_pend_q | halt;
        if (wait_cnt_q == '0) begin
          halt_pend_d = 1'b0;
          if (halt_pend_q | halt) begin
            flush_c = 1'b1;
            state_d = StHalted;
          end else begin
            state_d = StRun;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WaitW'(1);
        end
      end

      StHalted: begin
        busy_c = 1'b1;
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Strobes are forced to their safe values for as long as reset is held.
  assign pc_we        = rst_n & pc_we_c;
  assign if_id_we     = rst_n & if_id_we_c;
  assign id_ex_we     = rst_n & id_ex_we_c;
  assign id_ex_bubble = ~rst_n | bubble_c;
  assign if_id_flush  = ~rst_n | flush_c;
  assign busy         = rst_n & busy_c;

  // Nearer stage (EX/MEM, 01) takes precedence over MEM/WB (10).
  assign fwd_a_sel  = haz[1] ? 2'b01 : (haz[0] ? 2'b10 : 2'b00);
  assign fwd_b_sel  = (haz[2] | haz[8] | haz[10]) ? 2'b01 : ((haz[3] | haz[9]) ? 2'b10 : 2'b00);
  assign fwd_br_sel = (haz[4] | haz[6]) ? 2'b01 : ((haz[5] | haz[7]) ? 2'b10 : 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a  <= 2'b00;
      fwd_b  <= 2'b00;
      fwd_br <= 2'b00;
    end else if (id_ex_we_c) begin
      if (bubble_c) begin
        fwd_a  <= 2'b00;
        fwd_b  <= 2'b00;
        fwd_br <= 2'b00;
      end else begin
        fwd_a  <= fwd_a_sel;
        fwd_b  <= fwd_b_sel;
        fwd_br <= fwd_br_sel;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = ~pc_we_c & (state_q != StHalted);
  assign flush_inc = flush_c & (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: vector table, hand-written multi-cycle sequences and
// randomized cycles checked against a behavioural model.

module tb_pipeline_control_unit;

  localparam int unsigned MC     = 4;
  localparam int unsigned CW     = 4;
  localparam int          SatMax = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] haz;
  logic        haz_stall, branch_taken, muldiv_start, halt;
  logic        pc_we, if_id_we, id_ex_we, id_ex_bubble, if_id_flush, busy;
  logic [1:0]  fwd_a, fwd_b, fwd_br;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pipeline_control_unit #(.MULDIV_CYCLES(MC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .haz          (haz),
    .haz_stall    (haz_stall),
    .branch_taken (branch_taken),
    .muldiv_start (muldiv_start),
    .halt         (halt),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .id_ex_bubble (id_ex_bubble),
    .if_id_flush  (if_id_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .fwd_br       (fwd_br),
`ifdef PIPE_CTRL_PERF_EN
    .busy         (busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`else
    .busy         (busy)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_strobes(input string tag, input bit pc, input bit ifid, input bit idex,
                             input bit bub, input bit fl, input bit bsy);
    chk({tag, ".pc_we"}, 32'(pc_we), 32'(pc));
    chk({tag, ".if_id_we"}, 32'(if_id_we), 32'(ifid));
    chk({tag, ".id_ex_we"}, 32'(id_ex_we), 32'(idex));
    chk({tag, ".bubble"}, 32'(id_ex_bubble), 32'(bub));
    chk({tag, ".flush"}, 32'(if_id_flush), 32'(fl));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] br);
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
    chk({tag, ".fwd_br"}, 32'(fwd_br), 32'(br));
  endtask

  task automatic drive(input bit hs, input bit br, input bit md, input bit hl,
                       input logic [10:0] hz);
    haz_stall    = hs;
    branch_taken = br;
    muldiv_start = md;
    halt         = hl;
    haz          = hz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode 0 = running, 1 = waiting on MULT/DIV, 2 = halted.
  int         m_mode, m_left, m_sc, m_fc;
  bit         m_pend;
  logic [1:0] m_fa, m_fb, m_fbr;

  function automatic logic [1:0] sel(input bit near, input bit far);
    return near ? 2'b01 : (far ? 2'b10 : 2'b00);
  endfunction

  task automatic model_cycle(input bit do_rst, input string tag);
    bit e_pc, e_ifid, e_idex, e_bub, e_fl, e_busy;
    int nxt;
    rst_n = !do_rst;
    #2;
    if (do_rst) begin
      m_mode = 0; m_left = 0; m_pend = 0; m_sc = 0; m_fc = 0;
      m_fa = 2'b00; m_fb = 2'b00; m_fbr = 2'b00;
      chk_strobes({tag, ".rst"}, 0, 0, 0, 1, 1, 0);
      chk_fwd({tag, ".rst"}, m_fa, m_fb, m_fbr);
`ifdef PIPE_CTRL_PERF_EN
      chk({tag, ".rst.stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
      chk({tag, ".rst.flush_cnt"}, 32'(flush_cnt), 32'(m_fc));
`endif
      tick();
      return;
    end
    {e_pc, e_ifid, e_idex, e_bub, e_fl, e_busy} = '0;
    nxt = m_mode;
    if (m_mode == 0) begin
      if (halt) begin
        {e_idex, e_fl} = 2'b11;
        nxt = 2;
      end else if (branch_taken) begin
        {e_pc, e_ifid, e_idex, e_bub, e_fl} = 5'b11111;
      end else if (muldiv_start) begin
        {e_pc, e_ifid, e_idex} = 3'b111;
        m_left = MC;
        if (MC > 0) nxt = 1;
      end else if (haz_stall) begin
        {e_idex, e_bub} = 2'b11;
      end else begin
        {e_pc, e_ifid, e_idex} = 3'b111;
      end
    end else if (m_mode == 1) begin
      e_busy = 1;
      m_pend |= halt;
      m_left--;
      if (m_left == 0) begin
        e_fl   = m_pend;
        nxt    = m_pend ? 2 : 0;
        m_pend = 0;
      end
    end else begin
      e_busy = 1;
    end
    chk_strobes(tag, e_pc, e_ifid, e_idex, e_bub, e_fl, e_busy);
    if (!e_pc && m_mode != 2 && m_sc < SatMax) m_sc++;
    if (e_fl && m_mode == 0 && m_fc < SatMax) m_fc++;
    if (e_idex) begin
      if (e_bub) begin
        m_fa = 2'b00; m_fb = 2'b00; m_fbr = 2'b00;
      end else begin
        m_fa  = sel(haz[1], haz[0]);
        m_fb  = sel(haz[2] | haz[8] | haz[10], haz[3] | haz[9]);
        m_fbr = sel(haz[4] | haz[6], haz[5] | haz[7]);
      end
    end
    tick();
    m_mode = nxt;
    chk_fwd(tag, m_fa, m_fb, m_fbr);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_fc));
`endif
  endtask

  typedef struct {
    bit         hs, br, md, hl;
    logic [10:0] hz;
    bit         pc, ifid, idex, bub, fl;
    logic [1:0] fa, fb, fbr;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int busy_n;
    vecs[0]  = '{0, 0, 0, 0, 11'h000, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{0, 0, 0, 0, 11'h003, 1, 1, 1, 0, 0, 2'b01, 2'b00, 2'b00};
    vecs[2]  = '{0, 0, 0, 0, 11'h02C, 1, 1, 1, 0, 0, 2'b00, 2'b01, 2'b10};
    vecs[3]  = '{1, 0, 0, 0, 11'h7FF, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00};
    vecs[4]  = '{0, 0, 0, 0, 11'h000, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{1, 1, 1, 0, 11'h7FF, 1, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{0, 0, 0, 0, 11'h001, 1, 1, 1, 0, 0, 2'b10, 2'b00, 2'b00};
    vecs[7]  = '{0, 0, 0, 0, 11'h200, 1, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00};
    vecs[8]  = '{0, 0, 0, 0, 11'h600, 1, 1, 1, 0, 0, 2'b00, 2'b01, 2'b00};
    vecs[9]  = '{0, 0, 0, 0, 11'h100, 1, 1, 1, 0, 0, 2'b00, 2'b01, 2'b00};
    vecs[10] = '{0, 0, 0, 0, 11'h0C0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01};
    vecs[11] = '{0, 0, 0, 0, 11'h080, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10};
    vecs[12] = '{0, 0, 0, 0, 11'h008, 1, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00};
    vecs[13] = '{0, 0, 0, 0, 11'h010, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01};
    vecs[14] = '{0, 0, 0, 0, 11'h7FF, 1, 1, 1, 0, 0, 2'b01, 2'b01, 2'b01};

    // Reset held with a branch request: strobes must still show the reset values.
    rst_n = 1'b0;
    drive(0, 1, 0, 0, 11'h7FF);
    #3;
    chk_strobes("reset", 0, 0, 0, 1, 1, 0);
    chk_fwd("reset", 2'b00, 2'b00, 2'b00);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].hs, vecs[i].br, vecs[i].md, vecs[i].hl, vecs[i].hz);
      #2;
      chk_strobes($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].idex,
                  vecs[i].bub, vecs[i].fl, 0);
      tick();
      chk_fwd($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].fbr);
    end

    // MULT/DIV wait with halt arriving in wait cycle 2; other requests ignored meanwhile.
    drive(0, 0, 1, 0, 11'h003);
    #2;
    chk_strobes("md.start", 1, 1, 1, 0, 0, 0);
    tick();
    chk_fwd("md.start", 2'b01, 2'b00, 2'b00);
    for (int i = 1; i <= MC; i++) begin
      drive(1, 1, 0, (i == 2), 11'h7FF);
      #2;
      chk_strobes($sformatf("md.wait%0d", i), 0, 0, 0, 0, (i == MC), 1);
      tick();
      chk_fwd($sformatf("md.wait%0d", i), 2'b01, 2'b00, 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 11'h7FF);
      #2;
      chk_strobes($sformatf("halted%0d", i), 0, 0, 0, 0, 0, 1);
      tick();
    end

    // Reset asserted in the middle of a MULT/DIV wait.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 11'h000);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 11'h000);
    tick();
    drive(0, 0, 0, 0, 11'h000);
    tick();
    #2;
    chk("rstmid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_strobes("rstmid.during", 0, 0, 0, 1, 1, 0);
    tick();
    rst_n = 1'b1;
    #2;
    chk_strobes("rstmid.after", 1, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 11'h000);
    tick();
    drive(0, 0, 0, 0, 11'h000);
    busy_n = 0;
    for (int i = 0; i < MC + 4; i++) begin
      #2;
      if (busy === 1'b1) busy_n++;
      tick();
    end
    chk("md.busy_cycles", 32'(busy_n), 32'(MC));

`ifdef PIPE_CTRL_PERF_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 11'h000);
    for (int i = 0; i < 20; i++) tick();
    #2;
    chk("perf.stall_sat", 32'(stall_cnt), 32'(SatMax));
    chk("perf.flush_zero", 32'(flush_cnt), 32'd0);
    tick();
    drive(0, 1, 0, 0, 11'h000);
    for (int i = 0; i < 3; i++) tick();
    chk("perf.flush3", 32'(flush_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("perf.stall_rst", 32'(stall_cnt), 32'd0);
    chk("perf.flush_rst", 32'(flush_cnt), 32'd0);
    tick();
`endif

    // Randomized cycles against the model, with occasional resets to leave the halted state.
    drive(0, 0, 0, 0, 11'h000);
    model_cycle(1, "rnd_init");
    for (int i = 0; i < 400; i++) begin
      bit r;
      haz_stall    = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      muldiv_start = ($urandom_range(0, 6) == 0);
      halt         = ($urandom_range(0, 29) == 0);
      haz          = 11'($urandom);
      r = ((m_mode == 2) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 59) == 0);
      model_cycle(r, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
